// File: rtl/axi_wb_write_master.sv
// Write-back AXI master: one request -> one AXI4 INCR write burst fed from the async FIFO, done pulse after B.
// Latency len+4 cycles minimum; W valid/ready pass straight through to the FIFO. `AXI_WB_BRESP_CHECK_EN adds bresp error reporting.
module axi_wb_write_master #(
   parameter int ADDR_WIDTH          = 32,
   parameter int WRITE_CHANNEL_WIDTH = 32,
   parameter int WRITE_BURST_LEN     = 8
) (
   input  logic                             sys_clk,
   input  logic                             sys_rst,
   input  logic                             dma_write_back_happen,
   input  logic [ADDR_WIDTH-1:0]            dma_write_back_addr,
   input  logic [WRITE_BURST_LEN-1:0]       dma_write_back_burst_len,
   output logic                             dma_write_back_done,
   output logic                             dma_write_back_err,
   input  logic [WRITE_CHANNEL_WIDTH-1:0]   wb_data,
   input  logic                             wb_data_valid,
   output logic                             wb_data_ready,
   output logic [ADDR_WIDTH-1:0]            m_awaddr,
   output logic [7:0]                       m_awlen,
   output logic [2:0]                       m_awsize,
   output logic [1:0]                       m_awburst,
   output logic                             m_awvalid,
   input  logic                             m_awready,
   output logic [WRITE_CHANNEL_WIDTH-1:0]   m_wdata,
   output logic [WRITE_CHANNEL_WIDTH/8-1:0] m_wstrb,
   output logic                             m_wlast,
   output logic                             m_wvalid,
   input  logic                             m_wready,
   input  logic [1:0]                       m_bresp,
   input  logic                             m_bvalid,
   output logic                             m_bready
);

   localparam int         STRB_WIDTH = WRITE_CHANNEL_WIDTH / 8;
   localparam logic [2:0] AW_SIZE    = 3'($clog2(STRB_WIDTH));

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_e;

   state_e                     state_q, state_d;
   logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
   logic [WRITE_BURST_LEN-1:0] len_q, len_d;
   logic [WRITE_BURST_LEN-1:0] beat_q, beat_d;
   logic                       w_hs;
   logic                       last_beat;
   logic [7:0]                 awlen8;

   assign w_hs      = (state_q == S_W) && wb_data_valid && m_wready;
   assign last_beat = (beat_q == len_q);

   // AXI4 awlen is 8 bits regardless of the request field width.
   generate
      if (WRITE_BURST_LEN >= 8) begin : g_len_trunc
         assign awlen8 = len_q[7:0];
      end else begin : g_len_ext
         assign awlen8 = {{(8 - WRITE_BURST_LEN){1'b0}}, len_q};
      end
   endgenerate

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (dma_write_back_happen) state_d = S_AW;
         S_AW:    if (m_awready) state_d = S_W;
         S_W:     if (w_hs && last_beat) state_d = S_B;
         S_B:     if (m_bvalid) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Counter holds at len on the final beat, so it never wraps.
   always_comb begin
      addr_d = addr_q;
      len_d  = len_q;
      beat_d = beat_q;
      if (state_q == S_IDLE && dma_write_back_happen) begin
         addr_d = dma_write_back_addr;
         len_d  = dma_write_back_burst_len;
         beat_d = '0;
      end else if (w_hs && !last_beat) begin
         beat_d = beat_q + WRITE_BURST_LEN'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         addr_q <= '0;
         len_q  <= '0;
         beat_q <= '0;
      end else begin
         addr_q <= addr_d;
         len_q  <= len_d;
         beat_q <= beat_d;
      end
   end

`ifdef AXI_WB_BRESP_CHECK_EN
   logic [1:0] bresp_q, bresp_d;

   always_comb begin
      bresp_d = bresp_q;
      if (state_q == S_B && m_bvalid) bresp_d = m_bresp;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         bresp_q <= 2'b00;
      end else begin
         bresp_q <= bresp_d;
      end
   end

   // SLVERR and DECERR both have bit 1 set.
   assign dma_write_back_err = (state_q == S_DONE) && bresp_q[1];
`else
   logic unused_bresp;
   assign unused_bresp       = ^m_bresp;
   assign dma_write_back_err = 1'b0;
`endif

   always_comb begin
      m_awvalid           = 1'b0;
      m_awaddr            = '0;
      m_awlen             = '0;
      m_awsize            = '0;
      m_awburst           = '0;
      m_wvalid            = 1'b0;
      m_wdata             = '0;
      m_wstrb             = '0;
      m_wlast             = 1'b0;
      wb_data_ready       = 1'b0;
      m_bready            = 1'b0;
      dma_write_back_done = 1'b0;
      unique case (state_q)
         S_AW: begin
            m_awvalid = 1'b1;
            m_awaddr  = addr_q;
            m_awlen   = awlen8;
            m_awsize  = AW_SIZE;
            m_awburst = 2'b01;
         end
         S_W: begin
            m_wvalid      = wb_data_valid;
            wb_data_ready = m_wready;
            m_wdata       = wb_data;
            m_wstrb       = '1;
            m_wlast       = last_beat;
         end
         S_B:     m_bready = 1'b1;
         S_DONE:  dma_write_back_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_wb_write_master.sv
// Bench for axi_wb_write_master: FIFO and AXI slave models, a negedge monitor and per-scenario checks against pushed data.
`timescale 1ns/1ps
module tb_axi_wb_write_master;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 8;

   logic            sys_clk = 1'b0;
   logic            sys_rst = 1'b1;
   logic            dma_write_back_happen = 1'b0;
   logic [AW-1:0]   dma_write_back_addr = '0;
   logic [LW-1:0]   dma_write_back_burst_len = '0;
   logic            dma_write_back_done, dma_write_back_err;
   logic [DW-1:0]   wb_data = '0;
   logic            wb_data_valid = 1'b0;
   logic            wb_data_ready;
   logic [AW-1:0]   m_awaddr;
   logic [7:0]      m_awlen;
   logic [2:0]      m_awsize;
   logic [1:0]      m_awburst;
   logic            m_awvalid;
   logic            m_awready = 1'b1;
   logic [DW-1:0]   m_wdata;
   logic [DW/8-1:0] m_wstrb;
   logic            m_wlast, m_wvalid;
   logic            m_wready = 1'b1;
   logic [1:0]      m_bresp = 2'b00;
   logic            m_bvalid = 1'b0;
   logic            m_bready;

   always #5 sys_clk = ~sys_clk;

   axi_wb_write_master #(.ADDR_WIDTH(AW), .WRITE_CHANNEL_WIDTH(DW), .WRITE_BURST_LEN(LW)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .dma_write_back_happen(dma_write_back_happen), .dma_write_back_addr(dma_write_back_addr),
      .dma_write_back_burst_len(dma_write_back_burst_len),
      .dma_write_back_done(dma_write_back_done), .dma_write_back_err(dma_write_back_err),
      .wb_data(wb_data), .wb_data_valid(wb_data_valid), .wb_data_ready(wb_data_ready),
      .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Environment knobs and FIFO contents
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   int   aw_delay = 0, aw_wait = 0;
   int   gap_at = -1, gap_len = 0, gap_cnt = 0;
   bit   wready_rand = 1'b0;
   logic [1:0] bresp_cfg = 2'b00;
   bit   pop_pend = 1'b0, bset_pend = 1'b0, bclr_pend = 1'b0;
   int   burst_pops = 0;

   // Monitor records
   logic [AW-1:0] aw_addr_q[$];
   int   aw_len_q[$], aw_size_q[$], aw_burst_q[$], aw_cyc_q[$];
   logic [DW-1:0] w_dat_q[$];
   bit   w_last_q[$];
   int   done_cyc_q[$];
   bit   done_err_q[$];
   int   pops = 0, aw_unstable = 0, early_w = 0, wpass_bad = 0, w_idle = 0, err_stray = 0, strb_bad = 0;
   bit   aw_open = 1'b0, prev_awv = 1'b0;
   logic [AW+12:0] prev_aw = '0;

   always @(negedge sys_clk) begin
      if (sys_rst) begin
         aw_open  = 1'b0;
         prev_awv = 1'b0;
      end else begin
         if (m_awvalid && prev_awv && {m_awaddr, m_awlen, m_awsize, m_awburst} !== prev_aw) aw_unstable++;
         prev_aw  = {m_awaddr, m_awlen, m_awsize, m_awburst};
         prev_awv = m_awvalid && !m_awready;
         if (m_wvalid && !aw_open) early_w++;
         if (aw_open && m_wvalid !== wb_data_valid) wpass_bad++;
         if (m_wvalid && m_wdata !== wb_data) wpass_bad++;
         if (m_wvalid && m_wstrb !== '1) strb_bad++;
         if (aw_open && !m_wvalid) w_idle++;
         if (m_awvalid && m_awready) begin
            aw_addr_q.push_back(m_awaddr);
            aw_len_q.push_back(int'(m_awlen));
            aw_size_q.push_back(int'(m_awsize));
            aw_burst_q.push_back(int'(m_awburst));
            aw_cyc_q.push_back(cyc);
            aw_open = 1'b1;
         end
         if (m_wvalid && m_wready) begin
            w_dat_q.push_back(m_wdata);
            w_last_q.push_back(m_wlast);
            if (m_wlast) begin
               aw_open   = 1'b0;
               bset_pend = 1'b1;
            end
         end
         if (wb_data_valid && wb_data_ready) begin
            pops++;
            pop_pend = 1'b1;
         end
         if (m_bvalid && m_bready) bclr_pend = 1'b1;
         if (dma_write_back_err && !dma_write_back_done) err_stray++;
         if (dma_write_back_done) begin
            done_cyc_q.push_back(cyc);
            done_err_q.push_back(dma_write_back_err);
         end
      end
   end

   // FIFO and slave behaviour, updated just after each rising edge
   always @(posedge sys_clk) begin
      cyc++;
      #1;
      if (pop_pend) begin
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         burst_pops++;
         pop_pend = 1'b0;
      end
      if (bclr_pend) begin m_bvalid = 1'b0; bclr_pend = 1'b0; end
      if (bset_pend) begin m_bvalid = 1'b1; bset_pend = 1'b0; end
      if (sys_rst) m_bvalid = 1'b0;
      m_bresp   = bresp_cfg;
      m_awready = (aw_wait >= aw_delay);
      if (m_awvalid) aw_wait++; else aw_wait = 0;
      if (gap_at >= 0 && burst_pops == gap_at && gap_cnt < gap_len) begin
         wb_data_valid = 1'b0;
         gap_cnt++;
      end else begin
         wb_data_valid = (fifo_q.size() > 0);
      end
      wb_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      m_wready = wready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   function automatic logic [AW+DW+DW/8+18:0] all_outs();
      return {dma_write_back_done, dma_write_back_err, wb_data_ready, m_awaddr, m_awlen, m_awsize,
              m_awburst, m_awvalid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready};
   endfunction

   function automatic bit exp_err(input logic [1:0] resp);
`ifdef AXI_WB_BRESP_CHECK_EN
      return resp[1];
`else
      return 1'b0;
`endif
   endfunction

   task automatic clear_mon();
      aw_addr_q.delete(); aw_len_q.delete(); aw_size_q.delete(); aw_burst_q.delete(); aw_cyc_q.delete();
      w_dat_q.delete(); w_last_q.delete(); done_cyc_q.delete(); done_err_q.delete();
      pops = 0; aw_unstable = 0; early_w = 0; wpass_bad = 0; w_idle = 0; err_stray = 0; strb_bad = 0;
      burst_pops = 0; gap_cnt = 0;
   endtask

   // Loads ndata random words into the FIFO and raises a request; e0 is the cycle index of the sampling edge.
   task automatic start_req(input logic [AW-1:0] a, input int len, input int ndata, output int e0);
      logic [DW-1:0] d;
      clear_mon();
      fifo_q.delete();
      exp_q.delete();
      for (int i = 0; i < ndata; i++) begin
         d = $urandom;
         fifo_q.push_back(d);
         exp_q.push_back(d);
      end
      dma_write_back_happen    = 1'b1;
      dma_write_back_addr      = a;
      dma_write_back_burst_len = LW'(len);
      e0 = cyc + 1;
   endtask

   task automatic wait_done(input int n, input int budget, input bit drop);
      int k;
      k = 0;
      while (done_cyc_q.size() < n && k < budget) begin
         @(posedge sys_clk);
         k++;
      end
      #1;
      if (drop) dma_write_back_happen = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   function automatic int latency(input int e0);
      return (done_cyc_q.size() > 0) ? done_cyc_q[0] - e0 + 1 : -1;
   endfunction

   task automatic test_reset();
      sys_rst = 1'b1;
      idle(3);
      checks++;
      if (all_outs() !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", all_outs()); end
      sys_rst = 1'b0;
      idle(3);
      checks++;
      if (all_outs() !== '0) begin errors++; $display("FAIL idle_outputs: got %h required 0", all_outs()); end
   endtask

   task automatic test_long_burst();
      int e0, bad;
      start_req(32'd30, 22, 23, e0);
      wait_done(1, 300, 1'b1);
      idle(8);
      checks++;
      if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'd30 || aw_len_q[0] != 22 || aw_size_q[0] != 2 || aw_burst_q[0] != 1)
         begin errors++; $display("FAIL long_aw: count %0d addr %0d len %0d size %0d burst %0d, required 1/30/22/2/1",
            aw_addr_q.size(), aw_addr_q[0], aw_len_q[0], aw_size_q[0], aw_burst_q[0]); end
      checks++; bad = 0;
      for (int i = 0; i < 23; i++) if (w_dat_q.size() <= i || w_dat_q[i] !== exp_q[i] || w_last_q[i] !== (i == 22)) bad++;
      if (bad != 0 || w_dat_q.size() != 23) begin errors++; $display("FAIL long_beats: %0d bad, %0d beats, required 0 bad 23 beats", bad, w_dat_q.size()); end
      checks++;
      if (latency(e0) != 26) begin errors++; $display("FAIL long_latency: got %0d required 26", latency(e0)); end
      checks++;
      if (done_cyc_q.size() != 1 || done_err_q[0] !== 1'b0) begin errors++; $display("FAIL long_done: count %0d err %0d, required 1/0", done_cyc_q.size(), done_err_q[0]); end
      checks++;
      if (pops != 23 || early_w != 0 || wpass_bad != 0 || strb_bad != 0) begin errors++;
         $display("FAIL long_protocol: pops %0d early %0d pass %0d strb %0d, required 23/0/0/0", pops, early_w, wpass_bad, strb_bad); end
   endtask

   task automatic test_single_beat();
      int e0;
      start_req(32'h100, 0, 3, e0);
      wait_done(1, 50, 1'b1);
      idle(8);
      checks++;
      if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h100 || aw_len_q[0] != 0) begin errors++;
         $display("FAIL single_aw: count %0d addr %h len %0d, required 1/100/0", aw_addr_q.size(), aw_addr_q[0], aw_len_q[0]); end
      checks++;
      if (w_dat_q.size() != 1 || w_dat_q[0] !== exp_q[0] || w_last_q[0] !== 1'b1) begin errors++;
         $display("FAIL single_beat: beats %0d last %0d, required 1 beat with last", w_dat_q.size(), w_last_q[0]); end
      checks++;
      if (pops != 1 || fifo_q.size() != 2 || done_cyc_q.size() != 1 || latency(e0) != 4) begin errors++;
         $display("FAIL single_counts: pops %0d left %0d dones %0d lat %0d, required 1/2/1/4", pops, fifo_q.size(), done_cyc_q.size(), latency(e0)); end
   endtask

   task automatic test_aw_stall();
      int e0, bad;
      logic [AW-1:0] a;
      a = {$urandom, 2'b00};
      aw_delay = 5;
      start_req(a, 7, 8, e0);
      wait_done(1, 100, 1'b1);
      idle(4);
      aw_delay = 0;
      checks++;
      if (aw_unstable != 0 || aw_addr_q.size() != 1 || aw_addr_q[0] !== a || aw_len_q[0] != 7) begin errors++;
         $display("FAIL aw_stall_fields: unstable %0d count %0d addr %h len %0d, required 0/1/%h/7", aw_unstable, aw_addr_q.size(), aw_addr_q[0], aw_len_q[0], a); end
      checks++; bad = 0;
      for (int i = 0; i < 8; i++) if (w_dat_q.size() <= i || w_dat_q[i] !== exp_q[i] || w_last_q[i] !== (i == 7)) bad++;
      if (bad != 0 || w_dat_q.size() != 8 || early_w != 0) begin errors++;
         $display("FAIL aw_stall_beats: %0d bad %0d beats %0d early, required 0/8/0", bad, w_dat_q.size(), early_w); end
      checks++;
      if (latency(e0) != 16) begin errors++; $display("FAIL aw_stall_latency: got %0d required 16", latency(e0)); end
   endtask

   task automatic test_fifo_gap();
      int e0, bad;
      gap_at = 4; gap_len = 3;
      start_req(32'h2000, 7, 8, e0);
      wait_done(1, 100, 1'b1);
      idle(4);
      gap_at = -1;
      checks++;
      if (w_idle != 3 || wpass_bad != 0) begin errors++; $display("FAIL gap_wvalid: idle %0d pass %0d, required 3/0", w_idle, wpass_bad); end
      checks++; bad = 0;
      for (int i = 0; i < 8; i++) if (w_dat_q.size() <= i || w_dat_q[i] !== exp_q[i] || w_last_q[i] !== (i == 7)) bad++;
      if (bad != 0 || w_dat_q.size() != 8 || pops != 8) begin errors++;
         $display("FAIL gap_beats: %0d bad %0d beats %0d pops, required 0/8/8", bad, w_dat_q.size(), pops); end
      checks++;
      if (latency(e0) != 14) begin errors++; $display("FAIL gap_latency: got %0d required 14", latency(e0)); end
   endtask

   task automatic test_wready_random();
      int e0, bad, len;
      wready_rand = 1'b1;
      for (int it = 0; it < 5; it++) begin
         len = (it == 0) ? 7 : $urandom_range(0, 15);
         aw_delay = (it == 0) ? 0 : $urandom_range(0, 3);
         start_req({$urandom, 2'b00}, len, len + 1 + it, e0);
         wait_done(1, 400, 1'b1);
         idle(3);
         checks++; bad = 0;
         for (int i = 0; i <= len; i++) if (w_dat_q.size() <= i || w_dat_q[i] !== exp_q[i] || w_last_q[i] !== (i == len)) bad++;
         if (bad != 0 || w_dat_q.size() != len + 1 || pops != len + 1 || fifo_q.size() != it || wpass_bad != 0 || early_w != 0) begin errors++;
            $display("FAIL wready_burst%0d: bad %0d beats %0d pops %0d left %0d pass %0d early %0d, required len+1=%0d beats/pops, left %0d",
               it, bad, w_dat_q.size(), pops, fifo_q.size(), wpass_bad, early_w, len + 1, it); end
         checks++;
         if (aw_len_q.size() != 1 || aw_len_q[0] != len || done_cyc_q.size() != 1) begin errors++;
            $display("FAIL wready_aw%0d: aws %0d len %0d dones %0d, required 1/%0d/1", it, aw_len_q.size(), aw_len_q[0], done_cyc_q.size(), len); end
      end
      wready_rand = 1'b0;
      aw_delay = 0;
   endtask

   task automatic test_happen_held();
      int e0, bad, k;
      start_req(32'h40, 2, 6, e0);
      wait_done(1, 50, 1'b0);
      k = 0;
      while (aw_addr_q.size() < 2 && k < 20) begin @(posedge sys_clk); k++; end
      #1 dma_write_back_happen = 1'b0;
      wait_done(2, 50, 1'b1);
      idle(10);
      checks++;
      if (aw_cyc_q.size() != 2 || done_cyc_q.size() != 2 || aw_cyc_q[1] - done_cyc_q[0] != 2) begin errors++;
         $display("FAIL held_restart: aws %0d dones %0d gap %0d, required 2/2/2", aw_cyc_q.size(), done_cyc_q.size(), aw_cyc_q[1] - done_cyc_q[0]); end
      checks++; bad = 0;
      for (int i = 0; i < 6; i++) if (w_dat_q.size() <= i || w_dat_q[i] !== exp_q[i] || w_last_q[i] !== (i % 3 == 2)) bad++;
      if (bad != 0 || w_dat_q.size() != 6 || aw_addr_q[1] !== 32'h40 || aw_len_q[1] != 2) begin errors++;
         $display("FAIL held_beats: bad %0d beats %0d addr %h len %0d, required 0/6/40/2", bad, w_dat_q.size(), aw_addr_q[1], aw_len_q[1]); end
   endtask

   task automatic test_reset_mid();
      int e0, bad, k, snap;
      start_req(32'h800, 7, 8, e0);
      k = 0;
      while (w_dat_q.size() < 3 && k < 50) begin @(posedge sys_clk); k++; end
      #1;
      sys_rst = 1'b1;
      dma_write_back_happen = 1'b0;
      idle(1);
      checks++;
      if (all_outs() !== '0 || w_dat_q.size() != 3) begin errors++;
         $display("FAIL midreset_outputs: got %h after %0d beats, required 0 after 3", all_outs(), w_dat_q.size()); end
      snap = pops;
      idle(2);
      sys_rst = 1'b0;
      idle(6);
      checks++;
      if (done_cyc_q.size() != 0 || pops != snap || aw_addr_q.size() != 1 || all_outs() !== '0) begin errors++;
         $display("FAIL midreset_quiet: dones %0d pops %0d aws %0d outs %h, required 0/%0d/1/0", done_cyc_q.size(), pops, aw_addr_q.size(), all_outs(), snap); end
      start_req(32'h900, 3, 4, e0);
      wait_done(1, 50, 1'b1);
      idle(4);
      checks++; bad = 0;
      for (int i = 0; i < 4; i++) if (w_dat_q.size() <= i || w_dat_q[i] !== exp_q[i] || w_last_q[i] !== (i == 3)) bad++;
      if (bad != 0 || w_dat_q.size() != 4 || done_cyc_q.size() != 1 || latency(e0) != 7 || aw_addr_q[0] !== 32'h900) begin errors++;
         $display("FAIL midreset_recover: bad %0d beats %0d dones %0d lat %0d, required 0/4/1/7", bad, w_dat_q.size(), done_cyc_q.size(), latency(e0)); end
   endtask

   task automatic test_bresp();
      int e0;
      bresp_cfg = 2'b10;
      start_req(32'h1000, 1, 2, e0);
      wait_done(1, 50, 1'b1);
      idle(3);
      checks++;
      if (done_cyc_q.size() != 1 || done_err_q[0] !== exp_err(2'b10) || err_stray != 0) begin errors++;
         $display("FAIL bresp_slverr: dones %0d err %0d stray %0d, required 1/%0d/0", done_cyc_q.size(), done_err_q[0], err_stray, exp_err(2'b10)); end
      bresp_cfg = 2'b00;
      start_req(32'h1100, 1, 2, e0);
      wait_done(1, 50, 1'b1);
      idle(3);
      checks++;
      if (done_cyc_q.size() != 1 || done_err_q[0] !== 1'b0 || err_stray != 0) begin errors++;
         $display("FAIL bresp_okay: dones %0d err %0d stray %0d, required 1/0/0", done_cyc_q.size(), done_err_q[0], err_stray); end
   endtask

   initial begin
      test_reset();
      test_long_burst();
      test_single_beat();
      test_aw_stall();
      test_fifo_gap();
      test_wready_random();
      test_happen_held();
      test_reset_mid();
      test_bresp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
